// File: rtl/stream_framer.sv
// Byte-stuffing framer: wraps tagged pixel beats in SOF/SOL headers and escapes
// payload bytes that collide with marker values, one output byte per handshake.
module stream_framer #(
    parameter logic [7:0] SOF_BYTE = 8'hC0,
    parameter logic [7:0] SOL_BYTE = 8'hC1,
    parameter logic [7:0] ESC_BYTE = 8'hDB,
    parameter logic [7:0] ESC_XOR  = 8'h20
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  logic [7:0] s_data_i,
    input  logic       s_sof_i,
    input  logic       s_sol_i,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic [7:0] m_data_o,
    output logic [7:0] frame_cnt_o
);

    typedef enum logic [2:0] {IDLE, SOF_MK, FCNT, SOL_MK, ROW_HI, ROW_LO, PIX} state_t;

    state_t      r_state;
    logic        r_esc_pend;
    logic        r_run;
    logic [7:0]  r_pix;
    logic [15:0] r_row;
    logic [7:0]  r_frame_cnt;
    logic        r_m_valid;
    logic [7:0]  r_m_data;

    logic        w_out_free;
    logic        w_accept;
    logic        w_load;
    state_t      w_cur_state;
    state_t      w_next_state;
    logic [7:0]  w_cur_pix;
    logic [15:0] w_cur_row;
    logic [7:0]  w_payload;
    logic        w_is_payload;
    logic        w_needs_esc;
    logic        w_next_esc;
    logic [7:0]  w_byte;
    logic        w_fcnt_done;

    // r_run keeps the input side closed until the first clock after reset release.
    assign w_out_free = !r_m_valid || m_ready_i;
    assign s_ready_o  = r_run && (r_state == IDLE) && w_out_free;
    assign w_accept   = s_valid_i && s_ready_o;
    assign w_load     = ((r_state != IDLE) && w_out_free) || w_accept;

    // In IDLE the first byte of a new sequence is chosen straight from the input beat.
    always_comb begin
        w_cur_state = r_state;
        w_cur_pix   = r_pix;
        w_cur_row   = r_row;
        if (r_state == IDLE) begin
            w_cur_pix = s_data_i;
            if (s_sof_i) begin
                w_cur_state = SOF_MK;
                w_cur_row   = 16'd0;
            end else if (s_sol_i) begin
                w_cur_state = SOL_MK;
                w_cur_row   = r_row + 16'd1;
            end else begin
                w_cur_state = PIX;
            end
        end
    end

    always_comb begin
        w_payload    = w_cur_pix;
        w_is_payload = 1'b1;
        w_byte       = 8'h00;
        w_next_esc   = 1'b0;
        w_next_state = IDLE;
        case (w_cur_state)
            SOF_MK: begin w_is_payload = 1'b0; w_byte = SOF_BYTE; w_next_state = FCNT;   end
            FCNT:   begin w_payload = r_frame_cnt;                w_next_state = SOL_MK; end
            SOL_MK: begin w_is_payload = 1'b0; w_byte = SOL_BYTE; w_next_state = ROW_HI; end
            ROW_HI: begin w_payload = w_cur_row[15:8];            w_next_state = ROW_LO; end
            ROW_LO: begin w_payload = w_cur_row[7:0];             w_next_state = PIX;    end
            PIX:    begin                                         w_next_state = IDLE;   end
            default: begin w_is_payload = 1'b0;                   w_next_state = IDLE;   end
        endcase
        w_needs_esc = (w_payload == SOF_BYTE) || (w_payload == SOL_BYTE) || (w_payload == ESC_BYTE);
        if (w_is_payload) begin
            if (r_esc_pend) begin
                w_byte = w_payload ^ ESC_XOR;
            end else if (w_needs_esc) begin
                w_byte       = ESC_BYTE;
                w_next_esc   = 1'b1;
                w_next_state = w_cur_state;
            end else begin
                w_byte = w_payload;
            end
        end
    end

    // Frame count advances once its header byte (including any escape pair) is out.
    assign w_fcnt_done = w_load && (w_cur_state == FCNT) && !w_next_esc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_esc_pend  <= 1'b0;
            r_run       <= 1'b0;
            r_pix       <= 8'h00;
            r_row       <= 16'd0;
            r_frame_cnt <= 8'h00;
            r_m_valid   <= 1'b0;
            r_m_data    <= 8'h00;
        end else begin
            r_run <= 1'b1;
            if (w_load) begin
                r_m_valid  <= 1'b1;
                r_m_data   <= w_byte;
                r_state    <= w_next_state;
                r_esc_pend <= w_next_esc;
            end else if (w_out_free) begin
                r_m_valid <= 1'b0;
            end
            if (w_accept) begin
                r_pix <= s_data_i;
                r_row <= w_cur_row;
            end
            if (w_fcnt_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign m_valid_o   = r_m_valid;
    assign m_data_o    = r_m_data;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_stream_framer.sv
// Scoreboard bench for stream_framer: expected wire bytes are queued as beats are
// accepted and compared as the sink takes each output byte.
module tb_stream_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_sof = 1'b0;
    logic       s_sol = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]  exp_q[$];
    int          hs_cyc[$];
    logic [7:0]  m_frame = 8'h00;
    logic [15:0] m_row   = 16'd0;
    bit          rand_ready = 1'b0;
    bit          stalled = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    stream_framer dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .s_data_i   (s_data),
        .s_sof_i    (s_sof),
        .s_sol_i    (s_sol),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .m_data_o   (m_data),
        .frame_cnt_o(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Sink monitor: pops the scoreboard on every handshake, checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== stall_data)
                    $display("FAIL stall_stable: got valid=%b data=%h, required valid=1 data=%h", m_valid, m_data, stall_data);
                else
                    n_pass++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                hs_cyc.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_byte: got %h, required no byte", m_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) $display("FAIL out_byte: got %h, required %h", m_data, e);
                    else n_pass++;
                end
            end
            stalled    = (m_valid === 1'b1) && (m_ready !== 1'b1);
            stall_data = m_data;
        end
    end

    function automatic void push_payload(input logic [7:0] b);
        if (b == 8'hC0 || b == 8'hC1 || b == 8'hDB) begin
            exp_q.push_back(8'hDB);
            exp_q.push_back(b ^ 8'h20);
        end else begin
            exp_q.push_back(b);
        end
    endfunction

    function automatic void model_beat(input logic [7:0] d, input logic sof, input logic sol);
        if (sof) begin
            m_row = 16'd0;
            exp_q.push_back(8'hC0);
            push_payload(m_frame);
            m_frame = m_frame + 8'd1;
        end else if (sol) begin
            m_row = m_row + 16'd1;
        end
        if (sof || sol) begin
            exp_q.push_back(8'hC1);
            push_payload(m_row[15:8]);
            push_payload(m_row[7:0]);
        end
        push_payload(d);
    endfunction

    // Offers one beat; returns one cycle after acceptance (posedge + 1).
    task automatic send_beat(input logic [7:0] d, input logic sof, input logic sol, input bit use_model);
        int cnt;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_sol = sol;
        cnt = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (s_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL accept_timeout: s_ready=%b after %0d cycles, required 1", s_ready, cnt);
            s_valid = 1'b0;
        end else begin
            if (use_model) model_beat(d, sof, sol);
            $display("beat data=%h sof=%b sol=%b cycle=%0d", d, sof, sol, cyc);
            @(posedge clk);
            #1;
            s_valid = 1'b0; s_sof = 1'b0; s_sol = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: %0d bytes outstanding, required 0", name, exp_q.size());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || frame_cnt !== 8'h00)
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h fc=%h, required 0 0 00 00", s_ready, m_valid, m_data, frame_cnt);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_sof();
        exp_q.push_back(8'hC0); exp_q.push_back(8'h00); exp_q.push_back(8'hC1);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h12);
        m_frame = 8'd1; m_row = 16'd0;
        send_beat(8'h12, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hC0)
            $display("FAIL sof_latency: got vld=%b data=%h, required 1 c0", m_valid, m_data);
        else n_pass++;
        drain("sof");
        n_checks++;
        if (frame_cnt !== 8'd1) $display("FAIL sof_frame_cnt: got %h, required 01", frame_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'hC1); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h34); exp_q.push_back(8'h56);
        m_row = 16'd1;
        hs_cyc.delete();
        send_beat(8'h34, 1'b0, 1'b1, 1'b0);
        send_beat(8'h56, 1'b0, 1'b0, 1'b0);
        drain("b2b_sol");
        n_checks++;
        if (hs_cyc.size() != 5 || hs_cyc[hs_cyc.size()-1] - hs_cyc[0] != 4)
            $display("FAIL b2b_sol_gap: got %0d bytes over span %0d, required 5 over 4", hs_cyc.size(),
                     hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] - hs_cyc[0] : -1);
        else n_pass++;
        hs_cyc.delete();
        for (int i = 0; i < 4; i++) send_beat(8'h60 + 8'(i), 1'b0, 1'b0, 1'b1);
        drain("b2b_pix");
        n_checks++;
        if (hs_cyc.size() != 4 || hs_cyc[hs_cyc.size()-1] - hs_cyc[0] != 3)
            $display("FAIL b2b_pix_rate: got %0d bytes over span %0d, required 4 over 3", hs_cyc.size(),
                     hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] - hs_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_escape();
        exp_q.push_back(8'hDB); exp_q.push_back(8'hE0); exp_q.push_back(8'hDB);
        exp_q.push_back(8'hE1); exp_q.push_back(8'hDB); exp_q.push_back(8'hFB);
        send_beat(8'hC0, 1'b0, 1'b0, 1'b0);
        send_beat(8'hC1, 1'b0, 1'b0, 1'b0);
        send_beat(8'hDB, 1'b0, 1'b0, 1'b0);
        drain("escape");
    endtask

    task automatic test_row_wrap();
        send_beat(8'h01, 1'b1, 1'b0, 1'b1);
        drain("wrap_sof");
        force dut.r_row = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_row;
        exp_q.push_back(8'hC1); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hAA);
        exp_q.push_back(8'hC1); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hBB);
        m_row = 16'd0;
        send_beat(8'hAA, 1'b0, 1'b1, 1'b0);
        send_beat(8'hBB, 1'b0, 1'b1, 1'b0);
        drain("row_wrap");
    endtask

    task automatic test_frame_wrap();
        for (int i = 0; i < 256; i++) send_beat(8'(i), 1'b1, 1'b0, 1'b1);
        drain("frame_wrap");
        n_checks++;
        if (frame_cnt !== m_frame) $display("FAIL frame_wrap_cnt: got %h, required %h", frame_cnt, m_frame);
        else n_pass++;
    endtask

    task automatic test_random_stall();
        logic [7:0] d;
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0: d = 8'hC0;
                1: d = 8'hC1;
                2: d = 8'hDB;
                default: d = 8'($urandom_range(0, 255));
            endcase
            send_beat(d, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        drain("random");
        rand_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        exp_q.push_back(8'hC0);
        send_beat(8'h77, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || frame_cnt !== 8'h00)
            $display("FAIL mid_reset_clear: got vld=%b data=%h fc=%h, required 0 00 00", m_valid, m_data, frame_cnt);
        else n_pass++;
        exp_q.delete();
        m_frame = 8'h00; m_row = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_beat(8'h12, 1'b1, 1'b0, 1'b1);
        drain("mid_reset");
        n_checks++;
        if (frame_cnt !== 8'd1) $display("FAIL mid_reset_cnt: got %h, required 01", frame_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sof();
        test_back_to_back();
        test_escape();
        test_row_wrap();
        test_frame_wrap();
        test_random_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
